// File: rtl/fusion_seq.sv
// fusion_seq: drives one fusion_unit over a stream of operand pairs and accumulates
// a dot product. 8-bit elements are decomposed into four nibble passes whose psums
// are shifted and sign-interpreted on return.
module fusion_seq #(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned FU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_prec,
    input  logic             cfg_s_in,
    input  logic             cfg_s_weight,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_in,
    input  logic [7:0]       op_weight,
    input  logic             op_last,
    output logic [3:0]       fu_in,
    output logic [3:0]       fu_weight,
    output logic [2:0]       fu_in_width,
    output logic [2:0]       fu_weight_width,
    output logic             fu_s_in,
    output logic             fu_s_weight,
    input  logic [7:0]       fu_psum,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    // One entry per issued pass, aligned with the fusion_unit pipeline.
    typedef struct packed {
        logic       valid;
        logic [3:0] shift;
        logic       sgn;
    } tag_t;

    state_e           state_q, state_d;
    logic             prec_q, prec_d;
    logic             s_in_q, s_in_d;
    logic             s_w_q, s_w_d;
    logic [7:0]       in_q, in_d;
    logic [7:0]       w_q, w_d;
    logic             last_q, last_d;
    logic [1:0]       pass_q, pass_d;
    logic [3:0]       fu_in_q, fu_in_d;
    logic [3:0]       fu_weight_q, fu_weight_d;
    logic             fu_s_in_q, fu_s_in_d;
    logic             fu_s_weight_q, fu_s_weight_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             res_valid_q, res_valid_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    tag_t             tag_q [FU_LAT];
    tag_t             tag_d [FU_LAT];

    logic             issue;
    logic             acc_clr;
    logic             final_pass;
    logic [7:0]       src_in;
    logic [7:0]       src_w;
    logic             src_last;
    logic [3:0]       iss_shift;
    logic             iss_sgn;
    logic             tags_busy;
    tag_t             tag_exit;
    logic [ACC_W-1:0] psum_ext;

    assign op_ready        = (state_q == StRun) && (pass_q == 2'd0);
    assign busy            = (state_q != StIdle);
    assign fu_in           = fu_in_q;
    assign fu_weight       = fu_weight_q;
    assign fu_s_in         = fu_s_in_q;
    assign fu_s_weight     = fu_s_weight_q;
    assign fu_in_width     = 3'b100;
    assign fu_weight_width = 3'b100;
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
    assign tag_exit        = tag_q[FU_LAT-1];

    // Control FSM: accept, pass decomposition, drain and result handshake.
    always_comb begin
        state_d       = state_q;
        prec_d        = prec_q;
        s_in_d        = s_in_q;
        s_w_d         = s_w_q;
        in_d          = in_q;
        w_d           = w_q;
        last_d        = last_q;
        pass_d        = pass_q;
        fu_in_d       = fu_in_q;
        fu_weight_d   = fu_weight_q;
        fu_s_in_d     = fu_s_in_q;
        fu_s_weight_d = fu_s_weight_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        acc_clr       = 1'b0;
        issue         = 1'b0;
        final_pass    = 1'b0;
        src_in        = in_q;
        src_w         = w_q;
        src_last      = last_q;
        iss_shift     = 4'd0;
        iss_sgn       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    prec_d  = cfg_prec;
                    s_in_d  = cfg_s_in;
                    s_w_d   = cfg_s_weight;
                    acc_clr = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (pass_q != 2'd0) begin
                    issue = 1'b1;
                end else if (op_valid) begin
                    // Pass 0 issues straight from the bus in the accept cycle.
                    issue    = 1'b1;
                    in_d     = op_in;
                    w_d      = op_weight;
                    last_d   = op_last;
                    src_in   = op_in;
                    src_w    = op_weight;
                    src_last = op_last;
                end
                if (issue) begin
                    if (prec_q) begin
                        // pass[1] selects the in hi nibble, pass[0] the weight hi nibble.
                        fu_in_d       = pass_q[1] ? src_in[7:4] : src_in[3:0];
                        fu_weight_d   = pass_q[0] ? src_w[7:4] : src_w[3:0];
                        fu_s_in_d     = pass_q[1] & s_in_q;
                        fu_s_weight_d = pass_q[0] & s_w_q;
                        iss_shift     = {pass_q[1] & pass_q[0], pass_q[1] ^ pass_q[0], 2'b00};
                        pass_d        = pass_q + 2'd1;
                        final_pass    = (pass_q == 2'd3);
                    end else begin
                        fu_in_d       = src_in[3:0];
                        fu_weight_d   = src_w[3:0];
                        fu_s_in_d     = s_in_q;
                        fu_s_weight_d = s_w_q;
                        final_pass    = 1'b1;
                    end
                    iss_sgn = fu_s_in_d | fu_s_weight_d;
                    if (final_pass && src_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!tags_busy) begin
                    state_d     = StDone;
                    res_valid_d = 1'b1;
                    res_data_d  = acc_q;
                end
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Tag pipeline shift and accumulation of the returning psum.
    always_comb begin
        tag_d[0] = '{valid: issue, shift: iss_shift, sgn: iss_sgn};
        for (int i = 1; i < FU_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        tags_busy = 1'b0;
        for (int i = 0; i < FU_LAT; i++) begin
            tags_busy = tags_busy | tag_q[i].valid;
        end
        psum_ext = tag_exit.sgn ? {{(ACC_W-8){fu_psum[7]}}, fu_psum}
                                : {{(ACC_W-8){1'b0}}, fu_psum};
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (tag_exit.valid) begin
            acc_d = acc_q + (psum_ext << tag_exit.shift);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            prec_q        <= 1'b0;
            s_in_q        <= 1'b0;
            s_w_q         <= 1'b0;
            in_q          <= 8'd0;
            w_q           <= 8'd0;
            last_q        <= 1'b0;
            pass_q        <= 2'd0;
            fu_in_q       <= 4'd0;
            fu_weight_q   <= 4'd0;
            fu_s_in_q     <= 1'b0;
            fu_s_weight_q <= 1'b0;
            acc_q         <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            for (int i = 0; i < FU_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            prec_q        <= prec_d;
            s_in_q        <= s_in_d;
            s_w_q         <= s_w_d;
            in_q          <= in_d;
            w_q           <= w_d;
            last_q        <= last_d;
            pass_q        <= pass_d;
            fu_in_q       <= fu_in_d;
            fu_weight_q   <= fu_weight_d;
            fu_s_in_q     <= fu_s_in_d;
            fu_s_weight_q <= fu_s_weight_d;
            acc_q         <= acc_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            for (int i = 0; i < FU_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fusion_seq.sv
// tb_fusion_seq: directed vectors with a result scoreboard for fusion_seq.
// A behavioural fusion_unit returns the psum for the pass issued FU_LAT edges earlier.
module tb_fusion_seq;

    localparam int ACC_W  = 24;
    localparam int FU_LAT = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             cfg_prec = 1'b0;
    logic             cfg_s_in = 1'b0;
    logic             cfg_s_weight = 1'b0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [7:0]       op_in = 8'd0;
    logic [7:0]       op_weight = 8'd0;
    logic             op_last = 1'b0;
    logic [3:0]       fu_in;
    logic [3:0]       fu_weight;
    logic [2:0]       fu_in_width;
    logic [2:0]       fu_weight_width;
    logic             fu_s_in;
    logic             fu_s_weight;
    logic [7:0]       fu_psum;
    logic             busy;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [ACC_W-1:0] res_data;

    int               total = 0;
    int               bad = 0;
    logic [ACC_W-1:0] exp_q [$];
    logic [ACC_W-1:0] exp_v;
    logic [7:0]       psum_q;

    fusion_seq #(.ACC_W(ACC_W), .FU_LAT(FU_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_prec       (cfg_prec),
        .cfg_s_in       (cfg_s_in),
        .cfg_s_weight   (cfg_s_weight),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_in          (op_in),
        .op_weight      (op_weight),
        .op_last        (op_last),
        .fu_in          (fu_in),
        .fu_weight      (fu_weight),
        .fu_in_width    (fu_in_width),
        .fu_weight_width(fu_weight_width),
        .fu_s_in        (fu_s_in),
        .fu_s_weight    (fu_s_weight),
        .fu_psum        (fu_psum),
        .busy           (busy),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] nib_mul(input logic [3:0] a, input logic [3:0] b,
                                           input logic sa, input logic sb);
        int x;
        int y;
        int p;
        x = sa ? int'($signed(a)) : int'(a);
        y = sb ? int'($signed(b)) : int'(b);
        p = x * y;
        return p[7:0];
    endfunction

    // FU_LAT-1 register stage: psum is consumed at the FU_LAT-th edge after issue.
    always @(posedge clk) psum_q <= nib_mul(fu_in, fu_weight, fu_s_in, fu_s_weight);
    assign fu_psum = psum_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Result monitor: pops one expected value per completed handshake.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL res_unexpected: got %0h want none", res_data);
            end else begin
                exp_v = exp_q.pop_front();
                check("res_data", 32'(res_data), 32'(exp_v));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic prec, input logic si, input logic sw);
        cfg_prec     = prec;
        cfg_s_in     = si;
        cfg_s_weight = sw;
        start        = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Leaves op_valid high; caller drops it after the last pair.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        op_in     = a;
        op_weight = b;
        op_last   = last;
        op_valid  = 1'b1;
        n = 0;
        while (!op_ready && n < 20) begin
            step();
            n++;
        end
        if (!op_ready) begin
            total++;
            bad++;
            $display("FAIL op_ready_timeout: got 0 want 1");
        end
        step();
    endtask

    task automatic wait_result(input int exp_lat, input string name);
        int k;
        k = 0;
        while (!res_valid && k < 20) begin
            step();
            k++;
        end
        check(name, 32'(k), 32'(exp_lat));
    endtask

    task automatic finish_handshake(input string name);
        step();
        check({name, "_valid_low"}, 32'(res_valid), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_op_ready"}, 32'(op_ready), 32'd0);
        check({name, "_fu_in"}, 32'({fu_in, fu_weight}), 32'd0);
        check({name, "_fu_s"}, 32'({fu_s_in, fu_s_weight}), 32'd0);
        check({name, "_fu_width"}, 32'({fu_in_width, fu_weight_width}), 32'b100100);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_res_valid"}, 32'(res_valid), 32'd0);
        check({name, "_res_data"}, 32'(res_data), 32'd0);
    endtask

    logic [3:0] t_in [4] = '{4'hC, 4'hC, 4'h9, 4'h9};
    logic [3:0] t_w  [4] = '{4'h2, 4'h3, 4'h2, 4'h3};
    logic [1:0] t_s  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

    initial begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        step();
        step();
        rst = 1'b0;

        // 4-bit unsigned, back-to-back: 3*5 + 15*15 = 240
        begin_run(1'b0, 1'b0, 1'b0);
        exp_q.push_back(24'd240);
        check("t1_ready0", 32'(op_ready), 32'd1);
        send_pair(8'd3, 8'd5, 1'b0);
        check("t1_ready1", 32'(op_ready), 32'd1);
        send_pair(8'd15, 8'd15, 1'b1);
        op_valid = 1'b0;
        wait_result(3, "t1_latency");
        finish_handshake("t1");

        // 4-bit signed: -8 * 7 = -56
        begin_run(1'b0, 1'b1, 1'b1);
        exp_q.push_back(24'hFFFFC8);
        send_pair(8'h08, 8'h07, 1'b1);
        op_valid = 1'b0;
        wait_result(3, "t2_latency");
        finish_handshake("t2");

        // 8-bit signed: -100 * 50 = -5000, nibble passes checked one by one
        begin_run(1'b1, 1'b1, 1'b1);
        exp_q.push_back(24'hFFEC78);
        op_in    = 8'h9C;
        op_weight = 8'h32;
        op_last  = 1'b1;
        op_valid = 1'b1;
        check("t3_ready", 32'(op_ready), 32'd1);
        step();
        op_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("t3_pass%0d_nib", p), 32'({fu_in, fu_weight}), 32'({t_in[p], t_w[p]}));
            check($sformatf("t3_pass%0d_sgn", p), 32'({fu_s_in, fu_s_weight}), 32'(t_s[p]));
            if (p < 3) begin
                check($sformatf("t3_ready_low%0d", p), 32'(op_ready), 32'd0);
                step();
            end
        end
        wait_result(3, "t3_latency");
        finish_handshake("t3");

        // 8-bit unsigned: 255 * 255 = 65025
        begin_run(1'b1, 1'b0, 1'b0);
        exp_q.push_back(24'h00FE01);
        send_pair(8'hFF, 8'hFF, 1'b0 | 1'b1);
        op_valid = 1'b0;
        wait_result(6, "t4_latency");
        finish_handshake("t4");

        // 8-bit, signed in only, with a bubble: -128*255 + 127*2 = -32386
        begin_run(1'b1, 1'b1, 1'b0);
        exp_q.push_back(24'hFF817E);
        send_pair(8'h80, 8'hFF, 1'b0);
        op_valid = 1'b0;
        repeat (5) step();
        send_pair(8'h7F, 8'h02, 1'b1);
        op_valid = 1'b0;
        wait_result(6, "t5_latency");
        finish_handshake("t5");

        // Result held in DONE under backpressure; start must be ignored there
        res_ready = 1'b0;
        begin_run(1'b0, 1'b0, 1'b0);
        exp_q.push_back(24'd1);
        send_pair(8'd1, 8'd1, 1'b1);
        op_valid = 1'b0;
        wait_result(3, "t6_latency");
        for (int i = 0; i < 5; i++) begin
            start = (i == 1 || i == 2);
            step();
            check($sformatf("t6_hold_valid%0d", i), 32'(res_valid), 32'd1);
            check($sformatf("t6_hold_data%0d", i), 32'(res_data), 32'd1);
            check($sformatf("t6_hold_busy%0d", i), 32'(busy), 32'd1);
        end
        start = 1'b0;
        res_ready = 1'b1;
        finish_handshake("t6");

        // Reset during pass 2 of an 8-bit run, then a clean 4-bit run: 2*3 = 6
        begin_run(1'b1, 1'b1, 1'b1);
        op_in     = 8'h9C;
        op_weight = 8'h32;
        op_last   = 1'b1;
        op_valid  = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        step();
        check("t7_pass2_nib", 32'({fu_in, fu_weight}), 32'h92);
        rst = 1'b1;
        #1 check_reset_outputs("t7_reset");
        step();
        step();
        rst = 1'b0;
        begin_run(1'b0, 1'b0, 1'b0);
        exp_q.push_back(24'd6);
        send_pair(8'd2, 8'd3, 1'b1);
        op_valid = 1'b0;
        wait_result(3, "t7_latency");
        finish_handshake("t7");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
